// File: rtl/pifo_sr_pkg.sv
// Shared constants and types for the sorted shift-register PIFO.
// Pure definitions: no latency, no flow control.
package pifo_pkg;

  localparam int PIFO_OVF_BACKPRESSURE = 0;
  localparam int PIFO_OVF_EVICT        = 1;
  localparam int PIFO_OVF_DROP         = 2;

  typedef enum logic [1:0] {
    CELL_HOLD,
    CELL_LEFT,
    CELL_RIGHT,
    CELL_NEW
  } cell_sel_e;

  // A slot is packed as {valid, rank, meta}.
  function automatic int slot_width(input int rank_w, input int meta_w);
    return 1 + rank_w + meta_w;
  endfunction

endpackage

// File: rtl/pifo_sr_if.sv
// Insert / dequeue / drop / status bundle between classifier, PIFO and scheduler.
// Wires only; ins_ready is combinational from deq_ready in backpressure mode.
interface pifo_sr_if #(
  parameter int DEPTH      = 8,
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 32
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [RANK_WIDTH-1:0] ins_rank;
  logic [META_WIDTH-1:0] ins_meta;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [RANK_WIDTH-1:0] deq_rank;
  logic [META_WIDTH-1:0] deq_meta;
  logic [RANK_WIDTH-1:0] tail_rank;
  logic                  drop_valid;
  logic [RANK_WIDTH-1:0] drop_rank;
  logic [META_WIDTH-1:0] drop_meta;
  logic [31:0]           drop_count;
  logic [CNT_WIDTH-1:0]  num_entries;
  logic                  empty;
  logic                  full;

  modport master (
    output flush, ins_valid, ins_rank, ins_meta, deq_ready,
    input  ins_ready, deq_valid, deq_rank, deq_meta, tail_rank,
    input  drop_valid, drop_rank, drop_meta, drop_count, num_entries, empty, full
  );

  modport slave (
    input  flush, ins_valid, ins_rank, ins_meta, deq_ready,
    output ins_ready, deq_valid, deq_rank, deq_meta, tail_rank,
    output drop_valid, drop_rank, drop_meta, drop_count, num_entries, empty, full
  );
endinterface

// File: rtl/pifo_sr_cell.sv
// One PIFO slot register with a hold/left/right/new next-value mux; clr wins.
// One-cycle update; no flow control of its own, selects come from the top decoder.
module pifo_sr_cell
  import pifo_pkg::*;
#(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  cell_sel_e    sel,
  input  logic [W-1:0] left,
  input  logic [W-1:0] right,
  input  logic [W-1:0] new_slot,
  output logic [W-1:0] slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else begin
      case (sel)
        CELL_LEFT:  slot <= left;
        CELL_RIGHT: slot <= right;
        CELL_NEW:   slot <= new_slot;
        default:    slot <= slot;
      endcase
    end
  end

endmodule

// File: rtl/pifo_sr.sv
// Sorted shift-register PIFO: head is always the minimum rank, ties leave FIFO.
// Insert/dequeue take effect after one edge; overflow backpressures, evicts or drops per OVERFLOW_MODE.
module pifo_sr
  import pifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int RANK_WIDTH    = 16,
  parameter int META_WIDTH    = 32,
  parameter int OVERFLOW_MODE = PIFO_OVF_EVICT
) (
  input logic      clk,
  input logic      rst_n,
  pifo_sr_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int SW        = slot_width(RANK_WIDTH, META_WIDTH);

  typedef logic [SW-1:0]        slot_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  slot_t                 slot_q [DEPTH];
  cell_sel_e             sel    [DEPTH];
  logic [RANK_WIDTH-1:0] rank   [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      le;
  slot_t                 new_slot;
  cnt_t                  cnt_q, cnt_n, pos, pp;
  logic                  empty_q, full_q;
  logic                  ins, deq, room, ins_shift, drop_tail, drop_in;
  logic                  drop_vld_q;
  logic [RANK_WIDTH-1:0] drop_rank_q, tail;
  logic [META_WIDTH-1:0] drop_meta_q;
  logic [31:0]           drop_count_q;

  assign new_slot = {1'b1, bus.ins_rank, bus.ins_meta};

  for (genvar g = 0; g < DEPTH; g++) begin : g_field
    assign vld[g]  = slot_q[g][SW-1];
    assign rank[g] = slot_q[g][SW-2 -: RANK_WIDTH];
    assign le[g]   = vld[g] && (rank[g] <= bus.ins_rank);
  end

  assign bus.ins_ready = (OVERFLOW_MODE == PIFO_OVF_BACKPRESSURE) ? (!full_q || bus.deq_ready) : 1'b1;
  assign ins = bus.ins_valid && bus.ins_ready;
  assign deq = vld[0] && bus.deq_ready;

  // Contents are sorted, so le is a prefix and its popcount is the insert index.
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (le[i]) pos = pos + cnt_t'(1);
    end
  end

  assign room      = !full_q || (OVERFLOW_MODE == PIFO_OVF_EVICT && pos != cnt_t'(DEPTH));
  assign ins_shift = ins && !deq && room;
  assign drop_tail = ins_shift && full_q;
  assign drop_in   = ins && !deq && !room &&
                     (OVERFLOW_MODE == PIFO_OVF_EVICT || OVERFLOW_MODE == PIFO_OVF_DROP);

  always_comb begin
    pp = (pos == '0) ? cnt_t'(1) : pos;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = CELL_HOLD;
      if (ins && deq) begin
        // Slots ahead of the new entry slide toward the head to fill the dequeued gap.
        if (cnt_t'(i + 1) < pp)       sel[i] = CELL_RIGHT;
        else if (cnt_t'(i + 1) == pp) sel[i] = CELL_NEW;
      end else if (deq) begin
        sel[i] = CELL_RIGHT;
      end else if (ins_shift) begin
        if (cnt_t'(i) == pos)     sel[i] = CELL_NEW;
        else if (cnt_t'(i) > pos) sel[i] = CELL_LEFT;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    slot_t left_s, right_s;
    if (g == 0) begin : g_first
      assign left_s = '0;
    end else begin : g_mid_l
      assign left_s = slot_q[g-1];
    end
    if (g == DEPTH - 1) begin : g_last
      assign right_s = '0;
    end else begin : g_mid_r
      assign right_s = slot_q[g+1];
    end
    pifo_sr_cell #(.W(SW)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.flush),
      .sel      (sel[g]),
      .left     (left_s),
      .right    (right_s),
      .new_slot (new_slot),
      .slot     (slot_q[g])
    );
  end

  always_comb begin
    cnt_n = cnt_q;
    if (ins_shift && !full_q)  cnt_n = cnt_q + cnt_t'(1);
    else if (deq && !ins)      cnt_n = cnt_q - cnt_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      drop_vld_q   <= 1'b0;
      drop_rank_q  <= '0;
      drop_meta_q  <= '0;
      drop_count_q <= '0;
    end else if (bus.flush) begin
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      drop_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_n;
      empty_q    <= (cnt_n == '0);
      full_q     <= (cnt_n == cnt_t'(DEPTH));
      drop_vld_q <= drop_tail || drop_in;
      if (drop_tail) begin
        drop_rank_q <= rank[DEPTH-1];
        drop_meta_q <= slot_q[DEPTH-1][META_WIDTH-1:0];
      end else if (drop_in) begin
        drop_rank_q <= bus.ins_rank;
        drop_meta_q <= bus.ins_meta;
      end
      if ((drop_tail || drop_in) && drop_count_q != '1) drop_count_q <= drop_count_q + 32'd1;
    end
  end

  always_comb begin
    tail = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == cnt_t'(i + 1)) tail = rank[i];
    end
  end

  assign bus.deq_valid   = vld[0];
  assign bus.deq_rank    = rank[0];
  assign bus.deq_meta    = slot_q[0][META_WIDTH-1:0];
  assign bus.tail_rank   = tail;
  assign bus.drop_valid  = drop_vld_q;
  assign bus.drop_rank   = drop_rank_q;
  assign bus.drop_meta   = drop_meta_q;
  assign bus.drop_count  = drop_count_q;
  assign bus.num_entries = cnt_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;

endmodule

// File: tb/tb_pifo_sr.sv
// Directed bench: three DEPTH=4 PIFOs (backpressure, evict, drop) share one stimulus
// stream; each scenario checks the instance whose overflow mode it targets.
module tb_pifo_sr;
  import pifo_pkg::*;

  localparam int D  = 4;
  localparam int RW = 16;
  localparam int MW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          ins_valid = 1'b0;
  logic          deq_ready = 1'b0;
  logic [RW-1:0] ins_rank = '0;
  logic [MW-1:0] ins_meta = '0;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  pifo_sr_if #(.DEPTH(D), .RANK_WIDTH(RW), .META_WIDTH(MW)) if0 (), if1 (), if2 ();

  assign if0.flush = flush;  assign if0.ins_valid = ins_valid;  assign if0.deq_ready = deq_ready;
  assign if0.ins_rank = ins_rank;  assign if0.ins_meta = ins_meta;
  assign if1.flush = flush;  assign if1.ins_valid = ins_valid;  assign if1.deq_ready = deq_ready;
  assign if1.ins_rank = ins_rank;  assign if1.ins_meta = ins_meta;
  assign if2.flush = flush;  assign if2.ins_valid = ins_valid;  assign if2.deq_ready = deq_ready;
  assign if2.ins_rank = ins_rank;  assign if2.ins_meta = ins_meta;

  pifo_sr #(.DEPTH(D), .RANK_WIDTH(RW), .META_WIDTH(MW), .OVERFLOW_MODE(PIFO_OVF_BACKPRESSURE))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pifo_sr #(.DEPTH(D), .RANK_WIDTH(RW), .META_WIDTH(MW), .OVERFLOW_MODE(PIFO_OVF_EVICT))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pifo_sr #(.DEPTH(D), .RANK_WIDTH(RW), .META_WIDTH(MW), .OVERFLOW_MODE(PIFO_OVF_DROP))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [RW-1:0] r, input logic [MW-1:0] m);
    ins_valid = 1'b1;
    ins_rank  = r;
    ins_meta  = m;
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic pop();
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
  endtask

  initial begin
    int unsigned er1 [4] = '{2, 2, 5, 9};
    int unsigned em1 [4] = '{'hB, 'hD, 'hA, 'hC};
    int unsigned er3 [4] = '{0, 3, 5, 7};

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst num",        32'(if1.num_entries), 0);
    chk("rst empty",      32'(if1.empty), 1);
    chk("rst full",       32'(if1.full), 0);
    chk("rst deq_valid",  32'(if1.deq_valid), 0);
    chk("rst tail",       32'(if1.tail_rank), 0);
    chk("rst drop_valid", 32'(if1.drop_valid), 0);
    chk("rst drop_count", if1.drop_count, 0);
    chk("rst ins_ready0", 32'(if0.ins_ready), 1);
    #9 rst_n = 1'b1;
    tick();

    // sorted order with FIFO tie-break
    push(5, 'hA);
    chk("t1 first head", 32'(if1.deq_rank), 5);
    chk("t1 first vld",  32'(if1.deq_valid), 1);
    push(2, 'hB);
    push(9, 'hC);
    push(2, 'hD);
    chk("t1 num",  32'(if1.num_entries), 4);
    chk("t1 full", 32'(if1.full), 1);
    chk("t1 tail", 32'(if1.tail_rank), 9);
    for (int i = 0; i < 4; i++) begin
      chk("t1 pop rank", 32'(if1.deq_rank), er1[i]);
      chk("t1 pop meta", if1.deq_meta, em1[i]);
      pop();
    end
    chk("t1 empty", 32'(if1.empty), 1);
    pop();
    chk("t1 deq empty num", 32'(if1.num_entries), 0);

    // evict mode overflow
    push(1, 'h11);
    push(3, 'h13);
    push(5, 'h15);
    push(7, 'h17);
    push(4, 'h40);
    chk("t2 evict drop_valid", 32'(if1.drop_valid), 1);
    chk("t2 evict drop_rank",  32'(if1.drop_rank), 7);
    chk("t2 evict drop_meta",  if1.drop_meta, 'h17);
    chk("t2 evict head",       32'(if1.deq_rank), 1);
    chk("t2 evict tail",       32'(if1.tail_rank), 5);
    chk("t2 evict num",        32'(if1.num_entries), 4);
    push(8, 'h80);
    chk("t2 reject drop_valid", 32'(if1.drop_valid), 1);
    chk("t2 reject drop_rank",  32'(if1.drop_rank), 8);
    chk("t2 reject drop_meta",  if1.drop_meta, 'h80);
    chk("t2 reject tail",       32'(if1.tail_rank), 5);
    chk("t2 drop_count",        if1.drop_count, 2);
    tick();
    chk("t2 pulse ends",      32'(if1.drop_valid), 0);
    chk("t2 mode2 count",     if2.drop_count, 2);
    chk("t2 mode0 count",     if0.drop_count, 0);
    chk("t2 mode0 tail",      32'(if0.tail_rank), 7);

    // backpressure mode
    ins_valid = 1'b1;  ins_rank = 6;  ins_meta = 'h60;  deq_ready = 1'b0;
    #1;
    chk("t3 ready low", 32'(if0.ins_ready), 0);
    ins_rank = 0;  ins_meta = 'h0E;  deq_ready = 1'b1;
    #1;
    chk("t3 ready high", 32'(if0.ins_ready), 1);
    tick();
    ins_valid = 1'b0;  deq_ready = 1'b0;
    chk("t3 head",       32'(if0.deq_rank), 0);
    chk("t3 head meta",  if0.deq_meta, 'h0E);
    chk("t3 num",        32'(if0.num_entries), 4);
    chk("t3 no drop",    32'(if0.drop_valid), 0);
    chk("t3 drop_count", if0.drop_count, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3 pop rank", 32'(if0.deq_rank), er3[i]);
      pop();
    end

    // same-cycle insert and dequeue
    push(4, 'h4);
    push(6, 'h6);
    ins_valid = 1'b1;  ins_rank = 2;  ins_meta = 'h2;  deq_ready = 1'b1;
    tick();
    chk("t4 head", 32'(if1.deq_rank), 2);
    chk("t4 meta", if1.deq_meta, 'h2);
    chk("t4 num",  32'(if1.num_entries), 2);
    chk("t4 tail", 32'(if1.tail_rank), 6);
    ins_rank = 7;  ins_meta = 'h7;
    tick();
    ins_valid = 1'b0;  deq_ready = 1'b0;
    chk("t4b head", 32'(if1.deq_rank), 6);
    chk("t4b tail", 32'(if1.tail_rank), 7);
    chk("t4b num",  32'(if1.num_entries), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4 flush empty", 32'(if1.empty), 1);

    // reset in the middle of a fill
    push(3, 'h3);
    ins_valid = 1'b1;  ins_rank = 1;  ins_meta = 'h1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6 num",        32'(if1.num_entries), 0);
    chk("t6 empty",      32'(if1.empty), 1);
    chk("t6 full",       32'(if1.full), 0);
    chk("t6 deq_valid",  32'(if1.deq_valid), 0);
    chk("t6 deq_rank",   32'(if1.deq_rank), 0);
    chk("t6 deq_meta",   if1.deq_meta, 0);
    chk("t6 tail",       32'(if1.tail_rank), 0);
    chk("t6 drop_rank",  32'(if1.drop_rank), 0);
    chk("t6 drop_count", if2.drop_count, 0);
    chk("t6 ins_ready",  32'(if0.ins_ready), 1);
    ins_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // drop mode overflow, then flush with a pending insert
    push(3, 'h3);
    push(1, 'h1);
    push(2, 'h2);
    push(9, 'h9);
    chk("t5 full", 32'(if2.full), 1);
    push(0, 'hF0);
    chk("t5 drop_valid", 32'(if2.drop_valid), 1);
    chk("t5 drop_rank",  32'(if2.drop_rank), 0);
    chk("t5 drop_meta",  if2.drop_meta, 'hF0);
    chk("t5 head",       32'(if2.deq_rank), 1);
    chk("t5 head meta",  if2.deq_meta, 'h1);
    chk("t5 tail",       32'(if2.tail_rank), 9);
    chk("t5 drop_count", if2.drop_count, 1);
    flush = 1'b1;  ins_valid = 1'b1;  ins_rank = 5;  ins_meta = 'h55;
    #1;
    chk("t5 flush ready", 32'(if2.ins_ready), 1);
    tick();
    flush = 1'b0;  ins_valid = 1'b0;
    chk("t5 flush empty",      32'(if2.empty), 1);
    chk("t5 flush num",        32'(if2.num_entries), 0);
    chk("t5 flush deq_valid",  32'(if2.deq_valid), 0);
    chk("t5 flush no drop",    32'(if2.drop_valid), 0);
    chk("t5 flush drop_count", if2.drop_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
